// File: rtl/hit_scan_ctrl.sv
// rtl/hit_scan_ctrl.sv - time-multiplexed fixed-priority hit select (lowest index wins)
//
// Purpose:
//   Captures a snapshot of per-requester hit flags and payloads on start, then
//   walks the snapshot one group of GROUP_SIZE requesters per cycle. It stops
//   at the first group holding a set flag and reports the lowest set index in
//   that group, or reports "no hit" once the last group has been examined.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high
//   start      in   request a scan; honoured only while idle
//   flags_in   in   [INPUT_COUNT]           per-requester hit flags
//   data_in    in   [INPUT_WIDTH] x INPUT_COUNT per-requester payload
//   busy       out  high while scanning and in the done cycle
//   done       out  one-cycle pulse, results valid from this cycle
//   flag_out   out  any captured flag set
//   data_out   out  [INPUT_WIDTH]           payload of winning requester
//   index_out  out  [clog2(INPUT_COUNT)]    index of winning requester

module hit_scan_ctrl #(
  parameter int INPUT_COUNT = 64,
  parameter int INPUT_WIDTH = 6,
  parameter int GROUP_SIZE  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [INPUT_COUNT-1:0]         flags_in,
  input  logic [INPUT_WIDTH-1:0]         data_in [INPUT_COUNT],
  output logic                           busy,
  output logic                           done,
  output logic                           flag_out,
  output logic [INPUT_WIDTH-1:0]         data_out,
  output logic [$clog2(INPUT_COUNT)-1:0] index_out
);

  localparam int INDEX_WIDTH = $clog2(INPUT_COUNT);
  localparam int NUM_GROUPS  = INPUT_COUNT / GROUP_SIZE;
  localparam int GROUP_WIDTH = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  // Reject geometries the group walk cannot cover exactly.
  if ((INPUT_COUNT < 2) || ((INPUT_COUNT & (INPUT_COUNT - 1)) != 0) ||
      (GROUP_SIZE < 1) || ((INPUT_COUNT % GROUP_SIZE) != 0)) begin : g_bad_geometry
    $error("hit_scan_ctrl: INPUT_COUNT must be a power of two and a multiple of GROUP_SIZE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state;
  logic [GROUP_WIDTH-1:0]   group;
  logic [INPUT_COUNT-1:0]   cap_flags;
  logic [INPUT_WIDTH-1:0]   cap_data [INPUT_COUNT];

  logic                     grp_hit;
  logic [INDEX_WIDTH-1:0]   win_index;
  logic [INPUT_WIDTH-1:0]   win_data;
  logic                     last_group;

  // Lowest set flag within the current group. Walking from the top of the
  // group downwards lets the lowest index overwrite any higher one.
  always_comb begin
    int base;
    int j;
    grp_hit   = 1'b0;
    win_index = '0;
    base      = int'(group) * GROUP_SIZE;
    for (int i = GROUP_SIZE - 1; i >= 0; i--) begin
      j = base + i;
      if (cap_flags[j]) begin
        grp_hit   = 1'b1;
        win_index = INDEX_WIDTH'(j);
      end
    end
    win_data = cap_data[win_index];
  end

  assign last_group = (group == GROUP_WIDTH'(NUM_GROUPS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      group     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      flag_out  <= 1'b0;
      data_out  <= '0;
      index_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Snapshot so later input changes cannot disturb this scan.
            cap_flags <= flags_in;
            cap_data  <= data_in;
            group     <= '0;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end

        SCAN: begin
          if (grp_hit) begin
            flag_out  <= 1'b1;
            data_out  <= win_data;
            index_out <= win_index;
            done      <= 1'b1;
            state     <= DONE;
          end else if (last_group) begin
            flag_out  <= 1'b0;
            data_out  <= '0;
            index_out <= '0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            group <= group + GROUP_WIDTH'(1);
          end
        end

        DONE: begin
          // start is deliberately not examined here; it is taken next cycle.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hit_scan_ctrl.sv
// tb/tb_hit_scan_ctrl.sv - self-checking bench for hit_scan_ctrl
module tb_hit_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] flags_in;
  logic [5:0]  data_in [64];
  logic        busy;
  logic        done;
  logic        flag_out;
  logic [5:0]  data_out;
  logic [5:0]  index_out;

  int total  = 0;
  int passed = 0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  hit_scan_ctrl #(
    .INPUT_COUNT(64),
    .INPUT_WIDTH(6),
    .GROUP_SIZE (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .flags_in (flags_in),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .flag_out (flag_out),
    .data_out (data_out),
    .index_out(index_out)
  );

  always @(negedge clk) if (done === 1'b1) done_pulses++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [63:0] flags;
    int          ovr_idx;
    logic [5:0]  ovr_data;
    logic        exp_flag;
    logic [5:0]  exp_idx;
    logic [5:0]  exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fill_bg();
    for (int i = 0; i < 64; i++) data_in[i] = 6'(i) ^ 6'h2A;
  endtask

  // Called at a negedge; the following posedge is the capture edge k.
  // n counts negedges after edge k, so n equals the cycle offset from k.
  task automatic run_vec(input vec_t v, input int id);
    int n;
    int busy_bad;
    string tag;
    tag = $sformatf("vec%0d", id);
    fill_bg();
    data_in[v.ovr_idx] = v.ovr_data;
    flags_in = v.flags;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    busy_bad = 0;
    while (!done && n < 12) begin
      if (!busy) busy_bad++;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(v.exp_lat));
    check({tag, " busy_during"}, 64'(busy_bad), 64'd0);
    check({tag, " busy_at_done"}, 64'(busy), 64'd1);
    check({tag, " flag"}, 64'(flag_out), 64'(v.exp_flag));
    check({tag, " index"}, 64'(index_out), 64'(v.exp_idx));
    check({tag, " data"}, 64'(data_out), 64'(v.exp_data));
    @(negedge clk);
    check({tag, " done_one_cycle"}, 64'(done), 64'd0);
    check({tag, " busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n, dcnt, dcyc, pulses0, busy_bad;
    logic [63:0] rf;
    logic [5:0]  ref_idx, ref_data;
    logic        ref_flag;

    vecs[0] = '{64'h0000_0000_0000_0001,  0, 6'h2A, 1'b1, 6'd0,  6'h2A, 2};
    vecs[1] = '{64'h8000_0100_0000_0000, 40, 6'h11, 1'b1, 6'd40, 6'h11, 7};
    vecs[2] = '{64'h0000_0000_0000_0000,  0, 6'h3F, 1'b0, 6'd0,  6'h00, 9};
    vecs[3] = '{64'h0000_0000_0000_0080,  7, 6'h07, 1'b1, 6'd7,  6'h07, 2};
    vecs[4] = '{64'h8000_0000_0000_0100,  8, 6'h33, 1'b1, 6'd8,  6'h33, 3};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF,  0, 6'h01, 1'b1, 6'd0,  6'h01, 2};
    vecs[6] = '{64'h0100_0000_0000_0000, 56, 6'h3E, 1'b1, 6'd56, 6'h3E, 9};
    vecs[7] = '{64'h0000_0000_4006_0000, 17, 6'h05, 1'b1, 6'd17, 6'h05, 4};

    reset = 1'b1;
    start = 1'b1;
    flags_in = '1;
    fill_bg();
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset flag", 64'(flag_out), 64'd0);
    check("reset data", 64'(data_out), 64'd0);
    check("reset index", 64'(index_out), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Results hold while idle, regardless of input changes without start.
    flags_in = 64'h1;
    fill_bg();
    repeat (3) @(negedge clk);
    check("hold flag", 64'(flag_out), 64'd1);
    check("hold index", 64'(index_out), 64'd17);
    check("hold data", 64'(data_out), 64'h05);
    check("hold busy", 64'(busy), 64'd0);

    // Inputs change after capture and extra starts arrive mid-scan.
    fill_bg();
    data_in[63] = 6'h3F;
    flags_in = 64'h8000_0000_0000_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flags_in = '1;
    for (int i = 0; i < 64; i++) data_in[i] = 6'h00;
    dcnt = 0;
    dcyc = 0;
    for (int c = 1; c <= 14; c++) begin
      if (done) begin dcnt++; dcyc = c; end
      start = (c == 3) || (c == 5);
      @(negedge clk);
    end
    start = 1'b0;
    check("ignore done_count", 64'(dcnt), 64'd1);
    check("ignore done_cycle", 64'(dcyc), 64'd9);
    check("ignore index", 64'(index_out), 64'd63);
    check("ignore data", 64'(data_out), 64'h3F);

    // Reset mid-scan aborts; start held during reset is not taken.
    fill_bg();
    flags_in = 64'h0000_0000_0010_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    pulses0 = done_pulses;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort flag", 64'(flag_out), 64'd0);
    check("abort data", 64'(data_out), 64'd0);
    check("abort index", 64'(index_out), 64'd0);
    flags_in = 64'h20;
    data_in[5] = 6'h19;
    @(negedge clk);
    start = 1'b0;
    check("restart early_done", 64'(done), 64'd0);
    @(negedge clk);
    check("restart done", 64'(done), 64'd1);
    check("restart index", 64'(index_out), 64'd5);
    check("restart data", 64'(data_out), 64'h19);
    repeat (5) @(negedge clk);
    check("abort no_stray_done", 64'(done_pulses - pulses0), 64'd1);

    // Random back-to-back scans; start is raised in the done cycle and held.
    pulses0 = done_pulses;
    busy_bad = 0;
    for (int s = 0; s < 1000; s++) begin
      case ($urandom_range(0, 3))
        0: rf = 64'd0;
        1: rf = 64'd1 << $urandom_range(0, 63);
        2: rf = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        default: rf = {$urandom, $urandom};
      endcase
      flags_in = rf;
      for (int i = 0; i < 64; i++) data_in[i] = 6'($urandom);
      ref_flag = 1'b0;
      ref_idx  = 6'd0;
      ref_data = 6'd0;
      for (int i = 63; i >= 0; i--) begin
        if (rf[i]) begin
          ref_flag = 1'b1;
          ref_idx  = 6'(i);
          ref_data = data_in[i];
        end
      end
      start = 1'b1;
      if (s > 0) begin
        @(negedge clk);
        if (busy !== 1'b0) busy_bad++;
      end
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!done && n < 12) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("rand%0d done_seen", s), 64'(done), 64'd1);
      check($sformatf("rand%0d flag", s), 64'(flag_out), 64'(ref_flag));
      check($sformatf("rand%0d index", s), 64'(index_out), 64'(ref_idx));
      check($sformatf("rand%0d data", s), 64'(data_out), 64'(ref_data));
    end
    @(negedge clk);
    check("rand start_in_done_ignored", 64'(busy_bad), 64'd0);
    check("rand done_pulses", 64'(done_pulses - pulses0), 64'd1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
